// File: rtl/scroll_ctrl.sv
// Vertical-scroll row-offset sequencer: run/stop, direction, speed and single-step control.
// Optional build macro SCROLL_BOUNCE_EN selects ping-pong scrolling instead of modulo wrap.
module scroll_ctrl #(
  parameter int ROWS  = 240,
  parameter int OFF_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_start,
  input  logic             start_pulse,
  input  logic             dir_pulse,
  input  logic             step_pulse,
  input  logic [1:0]       speed,
  output logic [OFF_W-1:0] row_off,
  output logic             running,
  output logic             dir,
  output logic             wrap
);

  typedef enum logic [1:0] {STOP, RUN, STEP_PEND} state_t;

  localparam logic [OFF_W-1:0] LAST = OFF_W'(ROWS - 1);

  state_t           state;
  logic [2:0]       fcnt;
  logic [2:0]       limit;
  logic             take_step;
  logic [OFF_W-1:0] step_off;
  logic             step_wrap;
  logic             step_dir;

  assign limit = (3'd1 << speed) - 3'd1;

  // >= rather than == so a speed decrease mid-count steps on the very next frame
  assign take_step = frame_start && !start_pulse &&
                     ((state == RUN && fcnt >= limit) || state == STEP_PEND);

  always_comb begin
    step_off  = row_off;
    step_wrap = 1'b0;
    step_dir  = dir;
    if (!dir) begin
      if (row_off == '0) begin
        step_wrap = 1'b1;
`ifdef SCROLL_BOUNCE_EN
        step_off  = OFF_W'(1);
        step_dir  = 1'b1;
`else
        step_off  = LAST;
`endif
      end else begin
        step_off = row_off - 1'b1;
      end
    end else begin
      if (row_off == LAST) begin
        step_wrap = 1'b1;
`ifdef SCROLL_BOUNCE_EN
        step_off  = LAST - 1'b1;
        step_dir  = 1'b0;
`else
        step_off  = '0;
`endif
      end else begin
        step_off = row_off + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= STOP;
      fcnt    <= '0;
      row_off <= '0;
      dir     <= 1'b0;
      running <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (take_step) begin
        row_off <= step_off;
        wrap    <= step_wrap;
        // a bounce overrides a coincident dir_pulse
        dir     <= (step_dir != dir) ? step_dir : (dir ^ dir_pulse);
      end else if (dir_pulse) begin
        dir <= ~dir;
      end

      case (state)
        STOP: begin
          if (start_pulse) begin
            state   <= RUN;
            running <= 1'b1;
            fcnt    <= '0;
          end else if (step_pulse) begin
            state <= STEP_PEND;
          end
        end
        RUN: begin
          if (start_pulse) begin
            state   <= STOP;
            running <= 1'b0;
          end else if (frame_start) begin
            fcnt <= take_step ? 3'd0 : fcnt + 3'd1;
          end
        end
        STEP_PEND: begin
          if (start_pulse) begin
            state   <= RUN;
            running <= 1'b1;
            fcnt    <= '0;
          end else if (frame_start) begin
            state <= STOP;
          end
        end
        default: begin
          state   <= STOP;
          running <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scroll_ctrl.sv
// Directed self-checking bench for scroll_ctrl; define SCROLL_BOUNCE_EN to exercise ping-pong mode.
module tb_scroll_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       frame_start = 1'b0;
  logic       start_pulse = 1'b0;
  logic       dir_pulse = 1'b0;
  logic       step_pulse = 1'b0;
  logic [1:0] speed = 2'd0;
  logic [7:0] row_off;
  logic       running;
  logic       dir;
  logic       wrap;

  int checks = 0;
  int failures = 0;

  scroll_ctrl #(.ROWS(240), .OFF_W(8)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .start_pulse(start_pulse),
    .dir_pulse(dir_pulse), .step_pulse(step_pulse), .speed(speed),
    .row_off(row_off), .running(running), .dir(dir), .wrap(wrap)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs at a negedge; outputs are sampled at the following negedge.
  task automatic cyc(input logic fs, input logic st, input logic dp, input logic sp);
    frame_start = fs; start_pulse = st; dir_pulse = dp; step_pulse = sp;
    @(negedge clk);
    frame_start = 1'b0; start_pulse = 1'b0; dir_pulse = 1'b0; step_pulse = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(0, 0, 0, 0);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (row_off !== 8'd0 || running !== 1'b0 || dir !== 1'b0 || wrap !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: row_off=%0d running=%b dir=%b wrap=%b, want 0/0/0/0",
               row_off, running, dir, wrap);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 0);
      checks++;
      if (row_off !== 8'd0 || running !== 1'b0 || wrap !== 1'b0) begin
        failures++;
        $display("FAIL stop_ignores_frame[%0d]: row_off=%0d running=%b wrap=%b, want 0/0/0",
                 i, row_off, running, wrap);
      end
      cyc(0, 0, 0, 0);
    end
  endtask

  task automatic test_run_speed0();
    logic [7:0] exp_off [3];
    logic       exp_wrap [3];
    exp_off[0] = 8'd239; exp_off[1] = 8'd238; exp_off[2] = 8'd237;
    exp_wrap[0] = 1'b1;  exp_wrap[1] = 1'b0;  exp_wrap[2] = 1'b0;
    do_reset();
    speed = 2'd0;
    cyc(0, 1, 0, 0);
    checks++;
    if (running !== 1'b1 || row_off !== 8'd0) begin
      failures++;
      $display("FAIL run_enter: running=%b row_off=%0d, want 1/0", running, row_off);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 0);
      checks++;
      if (row_off !== exp_off[i] || wrap !== exp_wrap[i]) begin
        failures++;
        $display("FAIL run_step[%0d]: row_off=%0d wrap=%b, want %0d/%b",
                 i, row_off, wrap, exp_off[i], exp_wrap[i]);
      end
      cyc(0, 0, 0, 0);
      checks++;
      if (wrap !== 1'b0) begin
        failures++;
        $display("FAIL wrap_one_cycle[%0d]: wrap=%b, want 0", i, wrap);
      end
    end
  endtask

  task automatic test_speed();
    do_reset();
    speed = 2'd2;
    cyc(0, 1, 0, 0);
    for (int i = 1; i <= 8; i++) begin
      cyc(1, 0, 0, 0);
      if (i == 3 || i == 4 || i == 8) begin
        checks++;
        if (row_off !== ((i == 3) ? 8'd0 : (i == 4) ? 8'd239 : 8'd238)) begin
          failures++;
          $display("FAIL speed2_frame%0d: row_off=%0d, want %0d", i, row_off,
                   (i == 3) ? 0 : (i == 4) ? 239 : 238);
        end
      end
      cyc(0, 0, 0, 0);
    end
    // two frames into the next count, then drop to speed 0
    cyc(1, 0, 0, 0); cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0); cyc(0, 0, 0, 0);
    checks++;
    if (row_off !== 8'd238) begin
      failures++;
      $display("FAIL speed2_midcount: row_off=%0d, want 238", row_off);
    end
    speed = 2'd0;
    cyc(1, 0, 0, 0); cyc(0, 0, 0, 0);
    checks++;
    if (row_off !== 8'd237) begin
      failures++;
      $display("FAIL speed_change_first: row_off=%0d, want 237", row_off);
    end
    cyc(1, 0, 0, 0); cyc(0, 0, 0, 0);
    checks++;
    if (row_off !== 8'd236) begin
      failures++;
      $display("FAIL speed_change_second: row_off=%0d, want 236", row_off);
    end
  endtask

  task automatic test_step();
    do_reset();
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    checks++;
    if (row_off !== 8'd0 || running !== 1'b0) begin
      failures++;
      $display("FAIL step_pending: row_off=%0d running=%b, want 0/0", row_off, running);
    end
    cyc(1, 0, 0, 0);
    checks++;
    if (row_off !== 8'd239 || wrap !== 1'b1 || running !== 1'b0) begin
      failures++;
      $display("FAIL step_taken: row_off=%0d wrap=%b running=%b, want 239/1/0",
               row_off, wrap, running);
    end
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    checks++;
    if (row_off !== 8'd239 || wrap !== 1'b0) begin
      failures++;
      $display("FAIL step_single: row_off=%0d wrap=%b, want 239/0", row_off, wrap);
    end
  endtask

  task automatic test_dir_wrap();
    // continues from test_step: STOP, row_off=239, dir=0
    speed = 2'd0;
    cyc(0, 0, 1, 0);
    checks++;
    if (dir !== 1'b1) begin
      failures++;
      $display("FAIL dir_toggle: dir=%b, want 1", dir);
    end
    cyc(0, 1, 0, 0);
    cyc(1, 0, 0, 0);
    checks++;
    if (row_off !== 8'd0 || wrap !== 1'b1) begin
      failures++;
      $display("FAIL down_wrap: row_off=%0d wrap=%b, want 0/1", row_off, wrap);
    end
    cyc(1, 0, 0, 0);
    checks++;
    if (row_off !== 8'd1 || wrap !== 1'b0) begin
      failures++;
      $display("FAIL down_step: row_off=%0d wrap=%b, want 1/0", row_off, wrap);
    end
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 1);
    checks++;
    if (running !== 1'b1 || row_off !== 8'd1) begin
      failures++;
      $display("FAIL start_beats_step: running=%b row_off=%0d, want 1/1", running, row_off);
    end
    cyc(0, 1, 0, 0);
    cyc(1, 0, 0, 0);
    checks++;
    if (row_off !== 8'd1 || running !== 1'b0) begin
      failures++;
      $display("FAIL dropped_step: row_off=%0d running=%b, want 1/0", row_off, running);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    speed = 2'd0;
    cyc(1, 1, 0, 0);
    checks++;
    if (running !== 1'b1 || row_off !== 8'd0) begin
      failures++;
      $display("FAIL start_frame_stop: running=%b row_off=%0d, want 1/0", running, row_off);
    end
    cyc(1, 0, 0, 0);
    cyc(1, 1, 0, 0);
    checks++;
    if (running !== 1'b0 || row_off !== 8'd239) begin
      failures++;
      $display("FAIL start_frame_run: running=%b row_off=%0d, want 0/239", running, row_off);
    end
    cyc(0, 1, 0, 0);
    cyc(1, 0, 1, 0);
    checks++;
    if (row_off !== 8'd238 || dir !== 1'b1) begin
      failures++;
      $display("FAIL dir_with_step: row_off=%0d dir=%b, want 238/1", row_off, dir);
    end
    cyc(1, 0, 0, 0);
    checks++;
    if (row_off !== 8'd239) begin
      failures++;
      $display("FAIL new_dir_step: row_off=%0d, want 239", row_off);
    end
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 1);
    cyc(1, 1, 0, 0);
    checks++;
    if (running !== 1'b1 || row_off !== 8'd239) begin
      failures++;
      $display("FAIL start_frame_pend: running=%b row_off=%0d, want 1/239", running, row_off);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    speed = 2'd0;
    cyc(0, 1, 1, 0);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    rst = 1'b1;
    cyc(1, 1, 1, 1);
    rst = 1'b0;
    checks++;
    if (row_off !== 8'd0 || dir !== 1'b0 || running !== 1'b0 || wrap !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid: row_off=%0d dir=%b running=%b wrap=%b, want 0/0/0/0",
               row_off, dir, running, wrap);
    end
  endtask

`ifdef SCROLL_BOUNCE_EN
  task automatic test_bounce();
    do_reset();
    speed = 2'd0;
    cyc(0, 1, 1, 0);
    for (int i = 0; i < 237; i++) cyc(1, 0, 0, 0);
    checks++;
    if (row_off !== 8'd237 || dir !== 1'b1) begin
      failures++;
      $display("FAIL bounce_setup: row_off=%0d dir=%b, want 237/1", row_off, dir);
    end
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    checks++;
    if (row_off !== 8'd239 || wrap !== 1'b0) begin
      failures++;
      $display("FAIL bounce_top: row_off=%0d wrap=%b, want 239/0", row_off, wrap);
    end
    cyc(1, 0, 1, 0);
    checks++;
    if (row_off !== 8'd238 || dir !== 1'b0 || wrap !== 1'b1) begin
      failures++;
      $display("FAIL bounce: row_off=%0d dir=%b wrap=%b, want 238/0/1", row_off, dir, wrap);
    end
    cyc(1, 0, 0, 0);
    checks++;
    if (row_off !== 8'd237 || wrap !== 1'b0) begin
      failures++;
      $display("FAIL after_bounce: row_off=%0d wrap=%b, want 237/0", row_off, wrap);
    end
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
`ifdef SCROLL_BOUNCE_EN
    test_bounce();
`else
    test_run_speed0();
    test_speed();
    test_step();
    test_dir_wrap();
    test_simultaneous();
`endif
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
